// File: rtl/regfile_2r1w_pkg.sv
// Shared definitions for the 2-read/1-write register file: default geometry and
// the clear-controller state encoding.
package regfile_2r1w_pkg;

  localparam int unsigned AddrWDef = 5;
  localparam int unsigned DataWDef = 32;

  typedef enum logic {
    StClear = 1'b0,
    StIdle  = 1'b1
  } state_e;

endpackage

// File: rtl/regfile_clear_ctrl.sv
// Post-reset clear sequencer: walks every entry once, then reports idle.
// Flags writes that arrive while the sweep is still running.
module regfile_clear_ctrl
  import regfile_2r1w_pkg::*;
#(
  parameter int unsigned ADDR_W = AddrWDef
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              wr_en,
  output logic              busy,
  output logic              wr_drop,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_idx
);

  localparam logic [ADDR_W-1:0] TopIdx = '1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              busy_q, busy_d;
  logic              drop_q, drop_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    drop_d  = 1'b0;
    unique case (state_q)
      StClear: begin
        drop_d = wr_en;
        if (idx_q == TopIdx) begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end else begin
          idx_d = idx_q + ADDR_W'(1);
        end
      end
      StIdle: begin
        busy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= StClear;
      idx_q   <= '0;
      busy_q  <= 1'b1;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      drop_q  <= drop_d;
    end
  end

  assign clr_we  = (state_q == StClear);
  assign clr_idx = idx_q;
  assign busy    = busy_q;
  assign wr_drop = drop_q;

endmodule

// File: rtl/regfile_2r1w.sv
// General-purpose register file: two combinational read ports with write-first
// bypass, one synchronous write port, register 0 hardwired to zero.
module regfile_2r1w
  import regfile_2r1w_pkg::*;
#(
  parameter int unsigned ADDR_W = AddrWDef,
  parameter int unsigned DATA_W = DataWDef
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              wr_drop
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [Depth];
  logic              clr_we;
  logic [ADDR_W-1:0] clr_idx;
  logic              byp_en;

  regfile_clear_ctrl #(
    .ADDR_W (ADDR_W)
  ) u_clear_ctrl (
    .clk     (clk),
    .resetn  (resetn),
    .wr_en   (wr_en),
    .busy    (busy),
    .wr_drop (wr_drop),
    .clr_we  (clr_we),
    .clr_idx (clr_idx)
  );

  // A reset edge discards both the clear write and any user write.
  always_ff @(posedge clk) begin
    if (resetn) begin
      if (clr_we) begin
        mem[clr_idx] <= '0;
      end else if (wr_en && (wr_addr != '0)) begin
        mem[wr_addr] <= wr_data;
      end
    end
  end

  assign byp_en = wr_en && resetn && !busy;

  always_comb begin
    rd_data_a = '0;
    if (!busy && (rd_addr_a != '0)) begin
      if (byp_en && (wr_addr == rd_addr_a)) begin
        rd_data_a = wr_data;
      end else begin
        rd_data_a = mem[rd_addr_a];
      end
    end
  end

  always_comb begin
    rd_data_b = '0;
    if (!busy && (rd_addr_b != '0)) begin
      if (byp_en && (wr_addr == rd_addr_b)) begin
        rd_data_b = wr_data;
      end else begin
        rd_data_b = mem[rd_addr_b];
      end
    end
  end

endmodule

// File: tb/tb_regfile_2r1w.sv
// Self-checking bench for regfile_2r1w: directed vectors, reset/clear corner
// sequences and randomized traffic against a behavioural array model.
module tb_regfile_2r1w;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int N  = 32;

  logic          clk = 1'b0;
  logic          resetn;
  logic [AW-1:0] rd_addr_a, rd_addr_b, wr_addr;
  logic [DW-1:0] rd_data_a, rd_data_b, wr_data;
  logic          wr_en, busy, wr_drop;

  always #5 clk = ~clk;

  regfile_2r1w #(
    .ADDR_W (AW),
    .DATA_W (DW)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .rd_addr_a (rd_addr_a),
    .rd_data_a (rd_data_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_b (rd_data_b),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .wr_drop   (wr_drop)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: array contents plus remaining clear cycles.
  logic [DW-1:0] ref_mem [N];
  int            ref_left = 0;
  logic          ref_drop = 1'b0;

  typedef struct {
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [AW-1:0] ra;
    logic [AW-1:0] rb;
    logic [DW-1:0] ea;
    logic [DW-1:0] eb;
  } vec_t;

  vec_t tbl [10];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Update the model with the inputs present at this edge, then advance.
  task automatic tick();
    if (!resetn) begin
      for (int i = 0; i < N; i++) ref_mem[i] = '0;
      ref_left = N;
      ref_drop = 1'b0;
    end else if (ref_left > 0) begin
      ref_drop = wr_en;
      ref_left--;
    end else begin
      ref_drop = 1'b0;
      if (wr_en && wr_addr != 0) ref_mem[wr_addr] = wr_data;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
    if (ref_left > 0 || a == 0) return '0;
    if (wr_en && wr_addr == a) return wr_data;
    return ref_mem[a];
  endfunction

  task automatic check_model();
    check("rnd_busy", busy, (ref_left > 0));
    check("rnd_drop", wr_drop, ref_drop);
    if (resetn) begin
      check("rnd_rd_a", rd_data_a, model_read(rd_addr_a));
      check("rnd_rd_b", rd_data_b, model_read(rd_addr_b));
    end
  endtask

  initial begin
    tbl[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd0,  5'd0,  32'h0,        32'h0};
    tbl[1] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd6,  32'hDEADBEEF, 32'h0};
    tbl[2] = '{1'b1, 5'd9,  32'h1234,     5'd9,  5'd5,  32'h1234,     32'hDEADBEEF};
    tbl[3] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  32'h0,        32'h0};
    tbl[4] = '{1'b0, 5'd0,  32'h0,        5'd9,  5'd0,  32'h1234,     32'h0};
    tbl[5] = '{1'b1, 5'd9,  32'hABCD,     5'd9,  5'd9,  32'hABCD,     32'hABCD};
    tbl[6] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd9,  32'h0,        32'hABCD};
    tbl[7] = '{1'b1, 5'd31, 32'h77,       5'd1,  5'd30, 32'h0,        32'h0};
    tbl[8] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd9,  32'h77,       32'hABCD};
    tbl[9] = '{1'b1, 5'd2,  32'h5A5A,     5'd2,  5'd1,  32'h5A5A,     32'h0};

    resetn = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_addr_a = '0; rd_addr_b = '0;
    tick();
    resetn = 1'b1;

    // Clear sweep: busy for exactly N cycles, reads forced to zero.
    for (int i = 0; i < N; i++) begin
      rd_addr_a = AW'(i);
      #1;
      check("clr_busy", busy, 1'b1);
      check("clr_rd_a", rd_data_a, '0);
      tick();
    end
    check("clr_busy_low", busy, 1'b0);
    for (int i = 0; i < N; i++) begin
      rd_addr_a = AW'(i);
      rd_addr_b = AW'(N - 1 - i);
      #1;
      check("post_clr_a", rd_data_a, '0);
      check("post_clr_b", rd_data_b, '0);
    end

    // Directed IDLE vectors: writes, bypass, register 0, top index.
    foreach (tbl[k]) begin
      wr_en = tbl[k].we; wr_addr = tbl[k].wa; wr_data = tbl[k].wd;
      rd_addr_a = tbl[k].ra; rd_addr_b = tbl[k].rb;
      #1;
      check("vec_rd_a", rd_data_a, tbl[k].ea);
      check("vec_rd_b", rd_data_b, tbl[k].eb);
      check("vec_busy", busy, 1'b0);
      check("vec_drop", wr_drop, 1'b0);
      tick();
    end
    wr_en = 1'b0;

    // Mid-IDLE reset wipes contents and discards the write in the reset cycle.
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hA5;
    tick();
    wr_en = 1'b0; rd_addr_a = 5'd3;
    #1;
    check("a5_written", rd_data_a, 32'hA5);
    resetn = 1'b0; wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h55;
    tick();
    resetn = 1'b1; wr_en = 1'b0;
    for (int i = 0; i < N; i++) begin
      #1;
      check("rst_busy", busy, 1'b1);
      tick();
    end
    rd_addr_a = 5'd3; rd_addr_b = 5'd7;
    #1;
    check("rst_busy_low", busy, 1'b0);
    check("rst_addr3", rd_data_a, '0);
    check("rst_addr7", rd_data_b, '0);

    // Write during clear cycle 10 is dropped and flagged for one cycle.
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    for (int i = 0; i < N; i++) begin
      wr_en = (i == 10); wr_addr = 5'd5; wr_data = 32'hCAFE;
      #1;
      if (i == 10) check("drop_before", wr_drop, 1'b0);
      if (i == 11) check("drop_pulse", wr_drop, 1'b1);
      if (i == 12) check("drop_clear", wr_drop, 1'b0);
      tick();
    end
    wr_en = 1'b0; rd_addr_a = 5'd5;
    #1;
    check("drop_busy_low", busy, 1'b0);
    check("drop_entry", rd_data_a, '0);

    // Randomized traffic, including occasional resets.
    for (int n = 0; n < 600; n++) begin
      resetn  = ($urandom_range(0, 79) != 0);
      wr_en   = $urandom_range(0, 1);
      wr_addr = AW'($urandom_range(0, N - 1));
      wr_data = $urandom;
      rd_addr_a = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom_range(0, N - 1));
      rd_addr_b = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom_range(0, N - 1));
      #1;
      check_model();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
